// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Multi-ported register file with an attached scoreboard of busy bits.
//   Two write ports commit on the rising clock edge; port 1 wins when both
//   target the same register. An issue marks a register busy (writeback
//   pending), and a write to it clears the busy bit unless an issue targets
//   the same register in the same cycle (issue wins). Read ports are
//   combinational with write-through bypass of this cycle's write data and
//   busy state. Optionally register 0 is hardwired to zero and never busy.
//
// Parameters
//   DW       data width of every register and data port
//   AW       address width, depth = 2**AW
//   NRD      number of read ports
//   ZERO_REG 1: register 0 reads 0, ignores writes/issues, never busy
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   rd_addr_i   NRD read addresses, port k at [k*AW +: AW]
//   rd_data_o   NRD read data words, port k at [k*DW +: DW]
//   rd_busy_o   busy bit per read port (after bypass)
//   we0_i/rw0_i/rw0_data_i  write port 0: enable, address, data
//   we1_i/rw1_i/rw1_data_i  write port 1: enable, address, data
//   iss_i/iss_addr_i        issue: mark the addressed register busy
//   pend_cnt_o  registered count of busy registers
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*DW-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              we0_i,
  input  logic [AW-1:0]     rw0_i,
  input  logic [DW-1:0]     rw0_data_i,
  input  logic              we1_i,
  input  logic [AW-1:0]     rw1_i,
  input  logic [DW-1:0]     rw1_data_i,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic [AW:0]       pend_cnt_o
);

  localparam int DEPTH = 2 ** AW;
  localparam bit ZR    = (ZERO_REG != 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [AW:0]      pend_cnt_q;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // An address is usable unless it is the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return !(ZR && (a == '0));
  endfunction

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Qualified write/issue strobes and their one-hot decode. Accesses to the
  // zero register are filtered here so nothing downstream needs to care.
  // ---------------------------------------------------------------------------
  logic             wr0_ok;
  logic             wr1_ok;
  logic             iss_ok;
  logic [DEPTH-1:0] wr0_hit;
  logic [DEPTH-1:0] wr1_hit;
  logic [DEPTH-1:0] iss_hit;
  logic [DEPTH-1:0] busy_next;

  assign wr0_ok = we0_i && addr_ok(rw0_i);
  assign wr1_ok = we1_i && addr_ok(rw1_i);
  assign iss_ok = iss_i && addr_ok(iss_addr_i);

  always_comb begin
    wr0_hit   = '0;
    wr1_hit   = '0;
    iss_hit   = '0;
    busy_next = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr0_hit[r]   = wr0_ok && (rw0_i == AW'(r));
      wr1_hit[r]   = wr1_ok && (rw1_i == AW'(r));
      iss_hit[r]   = iss_ok && (iss_addr_i == AW'(r));
      // Issue dominates a same-cycle writeback; otherwise a write clears busy.
      busy_next[r] = iss_hit[r] | (busy_q[r] & ~(wr0_hit[r] | wr1_hit[r]));
    end
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr1_hit[r]) begin
          regs_q[r] <= rw1_data_i;
        end else if (wr0_hit[r]) begin
          regs_q[r] <= rw0_data_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and pending counter. The counter is the popcount of the next
  // busy vector, so it always matches busy_q after each edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_next;
      pend_cnt_q <= popcount(busy_next);
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  // ---------------------------------------------------------------------------
  // Read ports: combinational with bypass. While reset is low the outputs are
  // forced to zero so in-flight write data cannot leak through the bypass.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          written;

    assign a       = rd_addr_i[k*AW +: AW];
    assign written = wr0_hit[a] | wr1_hit[a];

    always_comb begin
      rd_data_o[k*DW +: DW] = '0;
      rd_busy_o[k]          = 1'b0;
      if (rst_n && addr_ok(a)) begin
        if (wr1_hit[a]) begin
          rd_data_o[k*DW +: DW] = rw1_data_i;
        end else if (wr0_hit[a]) begin
          rd_data_o[k*DW +: DW] = rw0_data_i;
        end else begin
          rd_data_o[k*DW +: DW] = regs_q[a];
        end
        // A writeback this cycle hides the busy bit unless re-issued now.
        rd_busy_o[k] = (written && !iss_hit[a]) ? 1'b0 : busy_q[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//   Drives two instances of regfile_sb (ZERO_REG=1 and ZERO_REG=0) with the
//   same stimulus and compares them against an array-based reference model:
//   directed scenarios first, then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic              we0_i, we1_i, iss_i;
  logic [AW-1:0]     rw0_i, rw1_i, iss_addr_i;
  logic [DW-1:0]     rw0_data_i, rw1_data_i;

  logic [NRD*DW-1:0] rd_data_z1, rd_data_z0;
  logic [NRD-1:0]    rd_busy_z1, rd_busy_z0;
  logic [AW:0]       pend_z1, pend_z0;

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z1),
    .rd_busy_o(rd_busy_z1), .we0_i(we0_i), .rw0_i(rw0_i), .rw0_data_i(rw0_data_i),
    .we1_i(we1_i), .rw1_i(rw1_i), .rw1_data_i(rw1_data_i), .iss_i(iss_i),
    .iss_addr_i(iss_addr_i), .pend_cnt_o(pend_z1)
  );

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z0),
    .rd_busy_o(rd_busy_z0), .we0_i(we0_i), .rw0_i(rw0_i), .rw0_data_i(rw0_data_i),
    .we1_i(we1_i), .rw1_i(rw1_i), .rw1_data_i(rw1_data_i), .iss_i(iss_i),
    .iss_addr_i(iss_addr_i), .pend_cnt_o(pend_z0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model. Index 0 models ZERO_REG=1, index 1 ZERO_REG=0.
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_regs [2][DEPTH];
  bit            m_busy [2][DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_zero_reg(int i, logic [AW-1:0] a);
    return (i == 0) && (a == 0);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[i][r] = '0;
        m_busy[i][r] = 1'b0;
      end
    end
  endfunction

  // Apply one clock edge: port 0 write, then port 1 write (so it wins),
  // each write retires the register; an issue re-marks it afterwards.
  function automatic void m_update(int i);
    if (we0_i && !is_zero_reg(i, rw0_i)) begin
      m_regs[i][rw0_i] = rw0_data_i;
      m_busy[i][rw0_i] = 1'b0;
    end
    if (we1_i && !is_zero_reg(i, rw1_i)) begin
      m_regs[i][rw1_i] = rw1_data_i;
      m_busy[i][rw1_i] = 1'b0;
    end
    if (iss_i && !is_zero_reg(i, iss_addr_i)) m_busy[i][iss_addr_i] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] m_read(int i, logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst_n || is_zero_reg(i, a)) return '0;
    v = m_regs[i][a];
    if (we0_i && rw0_i == a) v = rw0_data_i;
    if (we1_i && rw1_i == a) v = rw1_data_i;
    return v;
  endfunction

  function automatic bit m_read_busy(int i, logic [AW-1:0] a);
    bit wr;
    if (!rst_n || is_zero_reg(i, a)) return 1'b0;
    wr = (we0_i && rw0_i == a) || (we1_i && rw1_i == a);
    if (wr && !(iss_i && iss_addr_i == a)) return 1'b0;
    return m_busy[i][a];
  endfunction

  function automatic int m_count(int i);
    int c = 0;
    for (int r = 0; r < DEPTH; r++) c += int'(m_busy[i][r]);
    return c;
  endfunction

  function automatic logic [DW-1:0] dut_rd(int i, int k);
    return (i == 0) ? rd_data_z1[k*DW +: DW] : rd_data_z0[k*DW +: DW];
  endfunction

  function automatic logic dut_busy(int i, int k);
    return (i == 0) ? rd_busy_z1[k] : rd_busy_z0[k];
  endfunction

  function automatic logic [AW:0] dut_pend(int i);
    return (i == 0) ? pend_z1 : pend_z0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change just after the falling edge; cycle() checks
  // the combinational reads, steps the model on the rising edge, checks the
  // counter, and returns at the next falling edge.
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    we0_i = 0; rw0_i = '0; rw0_data_i = '0;
    we1_i = 0; rw1_i = '0; rw1_data_i = '0;
    iss_i = 0; iss_addr_i = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr[0 +: AW]  = a0;
    rd_addr[AW +: AW] = a1;
  endtask

  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd_data[%0d][%0d]", i, k), 64'(dut_rd(i, k)),
              64'(m_read(i, rd_addr[k*AW +: AW])));
        check($sformatf("rd_busy[%0d][%0d]", i, k), 64'(dut_busy(i, k)),
              64'(m_read_busy(i, rd_addr[k*AW +: AW])));
      end
    end
    @(posedge clk);
    if (rst_n) begin
      m_update(0);
      m_update(1);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pend_cnt[%0d]", i), 64'(dut_pend(i)), 64'(m_count(i)));
      check($sformatf("pend_bound[%0d]", i),
            64'(int'(dut_pend(i)) <= ((i == 0) ? DEPTH - 1 : DEPTH)), 64'(1));
    end
    @(negedge clk);
  endtask

  // Full-cycle reset with live write/issue traffic that must be ignored.
  task automatic do_reset();
    we0_i = 1; rw0_i = 5; rw0_data_i = 32'hAAAA_5555;
    we1_i = 1; rw1_i = 9; rw1_data_i = 32'hFFFF_FFFF;
    iss_i = 1; iss_addr_i = 9;
    set_rd(5, 9);
    rst_n = 0;
    m_clear();
    cycle();
    rst_n = 1;
    set_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [AW-1:0] rnd_addr();
    // Bias toward a small window so collisions between ports are frequent.
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                       : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 0;
    set_idle();
    set_rd(0, 0);
    m_clear();
    @(negedge clk);
    do_reset();

    // Scenario 1: write r5 via port 0, read on port 1 (bypass, then stored).
    set_rd(0, 5);
    check("s1_before", 64'(rd_data_z1[DW +: DW]), 64'(0));
    we0_i = 1; rw0_i = 5; rw0_data_i = 32'hDEAD_BEEF;
    #1 check("s1_bypass", 64'(rd_data_z1[DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    cycle();
    set_idle();
    #1;
    check("s1_after", 64'(rd_data_z1[DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    check("s1_busy", 64'(rd_busy_z1[1]), 64'(0));
    check("s1_cnt", 64'(pend_z1), 64'(0));
    cycle();

    // Scenario 2: same-cycle writes to r7, port 1 wins.
    set_rd(7, 7);
    we0_i = 1; rw0_i = 7; rw0_data_i = 32'h11;
    we1_i = 1; rw1_i = 7; rw1_data_i = 32'h22;
    #1 check("s2_bypass", 64'(rd_data_z1[0 +: DW]), 64'h22);
    cycle();
    set_idle();
    #1 check("s2_after", 64'(rd_data_z1[0 +: DW]), 64'h22);
    cycle();

    // Scenario 3: write and issue r0 on both ZERO_REG flavours.
    set_rd(0, 0);
    we0_i = 1; rw0_i = 0; rw0_data_i = 32'hFFFF;
    iss_i = 1; iss_addr_i = 0;
    cycle();
    set_idle();
    #1;
    check("s3_z1_data", 64'(rd_data_z1[0 +: DW]), 64'(0));
    check("s3_z1_busy", 64'(rd_busy_z1[0]), 64'(0));
    check("s3_z1_cnt", 64'(pend_z1), 64'(0));
    check("s3_z0_data", 64'(rd_data_z0[0 +: DW]), 64'hFFFF);
    check("s3_z0_busy", 64'(rd_busy_z0[0]), 64'(1));
    check("s3_z0_cnt", 64'(pend_z0), 64'(1));
    cycle();

    // Scenario 4: issue r3, r4, r9, then retire r3/r4 while re-issuing r9.
    do_reset();
    set_rd(9, 3);
    iss_i = 1; iss_addr_i = 3; cycle();
    check("s4_cnt1", 64'(pend_z1), 64'(1));
    iss_addr_i = 4; cycle();
    check("s4_cnt2", 64'(pend_z1), 64'(2));
    iss_addr_i = 9; cycle();
    check("s4_cnt3", 64'(pend_z1), 64'(3));
    we0_i = 1; rw0_i = 3; rw0_data_i = 32'h3333;
    we1_i = 1; rw1_i = 4; rw1_data_i = 32'h4444;
    iss_addr_i = 9;
    cycle();
    set_idle();
    #1;
    check("s4_cnt_final", 64'(pend_z1), 64'(1));
    check("s4_r9_busy", 64'(rd_busy_z1[0]), 64'(1));
    check("s4_r3_busy", 64'(rd_busy_z1[1]), 64'(0));
    cycle();

    // Scenario 5: issue and write r6 together; issue wins, data commits.
    set_rd(6, 6);
    iss_i = 1; iss_addr_i = 6;
    we0_i = 1; rw0_i = 6; rw0_data_i = 32'h5A;
    cycle();
    set_idle();
    #1;
    check("s5_data", 64'(rd_data_z1[0 +: DW]), 64'h5A);
    check("s5_busy", 64'(rd_busy_z1[0]), 64'(1));
    check("s5_cnt", 64'(pend_z1), 64'(2));
    cycle();

    // Scenario 6: asynchronous reset pulse between clock edges.
    do_reset();
    we0_i = 1; rw0_i = 2; rw0_data_i = 32'h1234; cycle();
    set_idle();
    iss_i = 1;
    for (int r = 1; r <= 4; r++) begin
      iss_addr_i = AW'(r);
      cycle();
    end
    check("s6_cnt_before", 64'(pend_z1), 64'(4));
    set_idle();
    set_rd(2, 3);
    we0_i = 1; rw0_i = 2; rw0_data_i = 32'hBEEF;
    rst_n = 0;
    m_clear();
    #1;
    check("s6_cnt_async", 64'(pend_z1), 64'(0));
    check("s6_cnt_async_z0", 64'(pend_z0), 64'(0));
    check("s6_rd_in_reset", 64'(rd_data_z1[0 +: DW]), 64'(0));
    check("s6_busy_in_reset", 64'(rd_busy_z1[1]), 64'(0));
    #1;
    rst_n = 1;
    set_idle();
    #1;
    check("s6_r2_cleared", 64'(rd_data_z1[0 +: DW]), 64'(0));
    check("s6_r3_not_busy", 64'(rd_busy_z1[1]), 64'(0));
    check("s6_cnt_after", 64'(pend_z1), 64'(0));
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        we0_i      = ($urandom_range(0, 2) == 0);
        rw0_i      = rnd_addr();
        rw0_data_i = $urandom;
        we1_i      = ($urandom_range(0, 2) == 0);
        rw1_i      = rnd_addr();
        rw1_data_i = $urandom;
        iss_i      = ($urandom_range(0, 1) == 0);
        iss_addr_i = rnd_addr();
        set_rd(rnd_addr(), rnd_addr());
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, SHALL set the data width of every register and data port in bits.
REQ-002 Parameter AW, default 5, SHALL set the register address width; depth SHALL be 2**AW.
REQ-003 Parameter NRD, default 2, SHALL set the number of read ports.
REQ-004 Parameter ZERO_REG, default 1, SHALL make register 0 hardwired to zero when 1; when 0, register 0 SHALL be an ordinary register.
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-007 rd_addr_i  in  NRD*AW  SHALL carry the read addresses; port k SHALL use bits [k*AW +: AW].
REQ-008 rd_data_o  out  NRD*DW  SHALL carry the read data; port k SHALL use bits [k*DW +: DW].
REQ-009 rd_busy_o  out  NRD  SHALL give the scoreboard busy bit of each read address after bypass.
REQ-010 we0_i, rw0_i, rw0_data_i  in  1/AW/DW  SHALL form write port 0: enable, address, data.
REQ-011 we1_i, rw1_i, rw1_data_i  in  1/AW/DW  SHALL form write port 1: enable, address, data.
REQ-012 iss_i, iss_addr_i  in  1/AW  SHALL mark the addressed register busy (pending writeback).
REQ-013 pend_cnt_o  out  AW+1  SHALL give the registered count of busy registers.

Function
REQ-014 A write SHALL commit on the rising clk edge when its enable is high.
REQ-015 If both write ports target one address in the same cycle, port 1 data SHALL win.
REQ-016 When ZERO_REG=1, writes, issues and busy state for address 0 SHALL be ignored, and reads of address 0 SHALL return 0 with busy 0.
REQ-017 Read ports SHALL be combinational.
- For an address not written this cycle, a read SHALL return the stored value.
- For an address written this cycle, a read SHALL return the incoming write data (write-through bypass, port 1 priority per REQ-015).
REQ-018 The busy bit of register r SHALL set on the edge where iss_i is high and iss_addr_i=r.
REQ-019 The busy bit of register r SHALL clear on the edge where any enabled write port targets r and no issue targets r.
REQ-020 A same-cycle issue and write to the same register SHALL leave the busy bit set (issue wins); the data SHALL still commit.
REQ-021 An issue to an already-busy register SHALL leave it busy; the count SHALL not change.
REQ-022 A write to a non-busy register SHALL commit data and leave busy at 0.
REQ-023 rd_busy_o[k] SHALL be 0 when a write to that address occurs this cycle and no issue targets it this cycle; otherwise it SHALL equal the stored busy bit.
REQ-024 pend_cnt_o SHALL equal the population count of the busy bits after each edge.
- Net change per cycle SHALL be within -2..+1.
- The count SHALL never exceed 2**AW (or 2**AW-1 when ZERO_REG=1).
REQ-025 Addresses SHALL be used unsigned; no out-of-range case exists, since depth=2**AW.

Reset
REQ-026 While rst_n is low, all registers, all busy bits and pend_cnt_o SHALL be 0, asynchronously, independent of clk.
REQ-027 Write and issue inputs SHALL have no effect while rst_n is low.
REQ-028 A reset asserted mid-operation SHALL discard all pending busy state.
REQ-029 The first edge after rst_n rises SHALL accept writes and issues normally.
REQ-030 While rst_n is low, rd_data_o SHALL read 0 for all addresses (bypass suppressed) and rd_busy_o SHALL be 0.

Verification
REQ-031 Scenario 1: reset, then write 0xDEADBEEF to r5 via port 0, then read r5 on port 1 -> read shows 0xDEADBEEF in the write cycle (bypass) and after it; busy=0; pend_cnt_o=0.
REQ-032 Scenario 2: same-cycle writes of 0x11 (port 0) and 0x22 (port 1) to r7 -> read shows 0x22 in the cycle and after it.
REQ-033 Scenario 3: write 0xFFFF to r0 and issue r0 with ZERO_REG=1 -> r0 reads 0; busy=0; pend_cnt_o=0. With ZERO_REG=0 -> r0 reads 0xFFFF; busy=1; pend_cnt_o=1.
REQ-034 Scenario 4: issue r3, r4, r9 on consecutive cycles -> pend_cnt_o steps to 1, 2, 3. Then write r3 and r4 together with a new issue of r9 -> pend_cnt_o=1; r9 busy.
REQ-035 Scenario 5: issue r6 and write r6=0x5A in the same cycle -> r6 reads 0x5A; busy=1; pend_cnt_o increments by 1.
REQ-036 Scenario 6: with 4 registers busy and r2=0x1234, pulse rst_n low between clock edges -> busy bits, pend_cnt_o and r2 go to 0 at once, without a clock edge.
